// File: rtl/wb_port_arbiter_if.sv
// Handshake and write-port bundle between WB stage, MDU and the regfile arbiter.
// Latency: none (signal container only).
// Backpressure: pipe_stall_o holds WB, mdu_ready_o gates MDU result acceptance.
interface wb_port_arbiter_if #(
    parameter int XLEN = 64
);
    logic            pipe_valid_i;
    logic            pipe_wen_i;
    logic [4:0]      pipe_rd_idx_i;
    logic [XLEN-1:0] pipe_rd_data_i;
    logic            pipe_stall_o;
    logic            mdu_valid_i;
    logic [4:0]      mdu_rd_idx_i;
    logic [XLEN-1:0] mdu_rd_data_i;
    logic            mdu_ready_o;
    logic            rf_wen_o;
    logic [4:0]      rf_waddr_o;
    logic [XLEN-1:0] rf_wdata_o;
    logic            mdu_pending_o;

    // Arbiter side
    modport slave (
        input  pipe_valid_i, pipe_wen_i, pipe_rd_idx_i, pipe_rd_data_i,
        input  mdu_valid_i, mdu_rd_idx_i, mdu_rd_data_i,
        output pipe_stall_o, mdu_ready_o, mdu_pending_o,
        output rf_wen_o, rf_waddr_o, rf_wdata_o
    );

    // Pipeline / MDU / regfile side
    modport master (
        output pipe_valid_i, pipe_wen_i, pipe_rd_idx_i, pipe_rd_data_i,
        output mdu_valid_i, mdu_rd_idx_i, mdu_rd_data_i,
        input  pipe_stall_o, mdu_ready_o, mdu_pending_o,
        input  rf_wen_o, rf_waddr_o, rf_wdata_o
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Regfile write-port arbiter: pipeline WB vs buffered MDU results (optional perf counters: WB_ARB_PERF_EN).
// Latency: granted write appears on rf_* one cycle after grant.
// Backpressure: pipe_stall_o on lost grant/WAW hazard/drain; mdu_ready_o low when the MDU FIFO is full.
module wb_port_arbiter #(
    parameter int XLEN           = 64,
    parameter int MDU_FIFO_DEPTH = 2,
    parameter int STARVE_MAX     = 4
) (
    input logic clk,
    input logic rst,
    wb_port_arbiter_if.slave bus
`ifdef WB_ARB_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles_o,
    output logic [31:0] perf_drain_entries_o
`endif
);
    localparam int AW = $clog2(MDU_FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(STARVE_MAX + 1);

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_DRAIN  = 1'b1
    } state_t;

    state_t state, state_nxt;

    // MDU result buffer
    logic [4:0]      fifo_rd  [MDU_FIFO_DEPTH];
    logic [XLEN-1:0] fifo_dat [MDU_FIFO_DEPTH];
    logic [AW:0]     rd_ptr, wr_ptr;
    logic [PW-1:0]   count, count_nxt;
    logic            fifo_empty, fifo_full;
    logic            push, pop;
    logic [4:0]      head_rd;
    logic [XLEN-1:0] head_dat;

    logic            hz;
    logic            grant_pipe, grant_mdu;
    logic [CW-1:0]   starve_cnt, starve_nxt;

    logic            rf_wen_q;
    logic [4:0]      rf_waddr_q;
    logic [XLEN-1:0] rf_wdata_q;

    assign count      = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_rd    = fifo_rd[rd_ptr[AW-1:0]];
    assign head_dat   = fifo_dat[rd_ptr[AW-1:0]];

    // Ready uses the pre-pop occupancy, so a full FIFO never takes a result even while it pops
    assign push      = bus.mdu_valid_i && !fifo_full;
    assign pop       = grant_mdu;
    assign count_nxt = count + PW'(push) - PW'(pop);

    // WAW hazard: pipe target matches any buffered (older) MDU destination
    always_comb begin
        logic [AW-1:0] idx;
        hz = 1'b0;
        for (int k = 0; k < MDU_FIFO_DEPTH; k++) begin
            idx = rd_ptr[AW-1:0] + AW'(k);
            if ((PW'(k) < count) && (fifo_rd[idx] == bus.pipe_rd_idx_i))
                hz = 1'b1;
        end
        hz = hz && bus.pipe_valid_i && bus.pipe_wen_i && (bus.pipe_rd_idx_i != 5'd0);
    end

    // Grant selection: pipe first in NORMAL, FIFO head only in DRAIN
    always_comb begin
        grant_pipe = 1'b0;
        grant_mdu  = 1'b0;
        if (state == ST_DRAIN) begin
            grant_mdu = !fifo_empty;
        end else if (bus.pipe_valid_i && !hz) begin
            grant_pipe = 1'b1;
        end else begin
            grant_mdu = !fifo_empty;
        end
    end

    // Starvation counter: counts pipe grants that bypass a waiting MDU result
    always_comb begin
        starve_nxt = starve_cnt;
        if (grant_mdu || fifo_empty) begin
            starve_nxt = '0;
        end else if (state == ST_NORMAL && grant_pipe && starve_cnt != CW'(STARVE_MAX)) begin
            starve_nxt = starve_cnt + CW'(1);
        end
    end

    // Next state: enter DRAIN on full FIFO or starvation, leave once empty with no refill
    always_comb begin
        state_nxt = state;
        case (state)
            ST_NORMAL: begin
                if (count_nxt == PW'(MDU_FIFO_DEPTH) ||
                    (starve_nxt == CW'(STARVE_MAX) && count_nxt != '0))
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (count_nxt == '0)
                    state_nxt = ST_NORMAL;
            end
            default: state_nxt = ST_NORMAL;
        endcase
    end

    // State, pointers and starvation counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_NORMAL;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // FIFO storage; contents are don't-care until written, validity lives in the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr[AW-1:0]]  <= bus.mdu_rd_idx_i;
            fifo_dat[wr_ptr[AW-1:0]] <= bus.mdu_rd_data_i;
        end
    end

    // Registered regfile write; x0 targets are consumed without a write
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else if (grant_pipe) begin
            rf_wen_q   <= bus.pipe_wen_i && (bus.pipe_rd_idx_i != 5'd0);
            rf_waddr_q <= bus.pipe_rd_idx_i;
            rf_wdata_q <= bus.pipe_rd_data_i;
        end else if (grant_mdu) begin
            rf_wen_q   <= (head_rd != 5'd0);
            rf_waddr_q <= head_rd;
            rf_wdata_q <= head_dat;
        end else begin
            rf_wen_q   <= 1'b0;
        end
    end

    assign bus.pipe_stall_o  = bus.pipe_valid_i && !grant_pipe;
    assign bus.mdu_ready_o   = !fifo_full;
    assign bus.mdu_pending_o = !fifo_empty;
    assign bus.rf_wen_o      = rf_wen_q;
    assign bus.rf_waddr_o    = rf_waddr_q;
    assign bus.rf_wdata_o    = rf_wdata_q;

`ifdef WB_ARB_PERF_EN
    // Stall-cycle (saturating) and drain-entry counters
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles_o  <= '0;
            perf_drain_entries_o <= '0;
        end else begin
            if (bus.pipe_stall_o && perf_stall_cycles_o != 32'hFFFF_FFFF)
                perf_stall_cycles_o <= perf_stall_cycles_o + 32'd1;
            if (state == ST_NORMAL && state_nxt == ST_DRAIN)
                perf_drain_entries_o <= perf_drain_entries_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios then random traffic against a queue-based reference.
// Latency: reference predicts rf_* one cycle after each grant.
// Backpressure: reference models stall, ready and drain behaviour.
module tb_wb_port_arbiter;
    localparam int XLEN  = 64;
    localparam int DEPTH = 2;
    localparam int SMAX  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_port_arbiter_if #(.XLEN(XLEN)) bus ();

`ifdef WB_ARB_PERF_EN
    logic [31:0] perf_stall_cycles, perf_drain_entries;
`endif

    wb_port_arbiter #(
        .XLEN(XLEN), .MDU_FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef WB_ARB_PERF_EN
        ,
        .perf_stall_cycles_o  (perf_stall_cycles),
        .perf_drain_entries_o (perf_drain_entries)
`endif
    );

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] dat;
    } ent_t;

    // Reference state: buffered MDU results in arrival order plus the visible write
    ent_t            q[$];
    bit              m_drain;
    int              m_starve;
    logic            m_wen;
    logic [4:0]      m_addr;
    logic [XLEN-1:0] m_data;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_drain  = 1'b0;
        m_starve = 0;
        m_wen    = 1'b0;
        m_addr   = '0;
        m_data   = '0;
    endtask

    // One clock: drive inputs, check at negedge, advance the reference
    task automatic step(input bit r, input bit pv, input bit pw, input logic [4:0] prd,
                        input logic [XLEN-1:0] pd, input bit mv, input logic [4:0] mrd,
                        input logic [XLEN-1:0] md);
        bit hz, gp, gm, ready, push, was_empty;
        rst                = r;
        bus.pipe_valid_i   = pv;
        bus.pipe_wen_i     = pw;
        bus.pipe_rd_idx_i  = prd;
        bus.pipe_rd_data_i = pd;
        bus.mdu_valid_i    = mv;
        bus.mdu_rd_idx_i   = mrd;
        bus.mdu_rd_data_i  = md;
        @(negedge clk);
        check_val("rf_wen", XLEN'(bus.rf_wen_o), XLEN'(m_wen));
        if (m_wen) begin
            check_val("rf_waddr", XLEN'(bus.rf_waddr_o), XLEN'(m_addr));
            check_val("rf_wdata", bus.rf_wdata_o, m_data);
        end
        if (r) begin
            model_reset();
        end else begin
            hz = 1'b0;
            if (pv && pw && prd != 5'd0)
                foreach (q[k]) if (q[k].rd == prd) hz = 1'b1;
            ready     = (q.size() < DEPTH);
            was_empty = (q.size() == 0);
            gp = !m_drain && pv && !hz;
            gm = !gp && !was_empty;
            push = mv && ready;
            check_val("stall", XLEN'(bus.pipe_stall_o), XLEN'(pv && !gp));
            check_val("ready", XLEN'(bus.mdu_ready_o), XLEN'(ready));
            check_val("pending", XLEN'(bus.mdu_pending_o), XLEN'(!was_empty));
            if (gp) begin
                m_wen = pw && (prd != 5'd0); m_addr = prd; m_data = pd;
            end else if (gm) begin
                m_wen = (q[0].rd != 5'd0); m_addr = q[0].rd; m_data = q[0].dat;
            end else begin
                m_wen = 1'b0;
            end
            if (gm) void'(q.pop_front());
            if (push) q.push_back('{rd: mrd, dat: md});
            if (gm || was_empty) m_starve = 0;
            else if (gp && m_starve < SMAX) m_starve++;
            if (!m_drain)
                m_drain = (q.size() == DEPTH) || (m_starve == SMAX && q.size() != 0);
            else if (q.size() == 0)
                m_drain = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 5'd0, '0, 0, 5'd0, '0);
    endtask

    initial begin
        bit              pv, pw, mv, r;
        logic [4:0]      prd, mrd;
        logic [XLEN-1:0] pd, md;

        model_reset();
        step(1, 0, 0, 5'd0, '0, 0, 5'd0, '0);
        step(1, 0, 0, 5'd0, '0, 0, 5'd0, '0);
        check_val("reset_waddr", XLEN'(bus.rf_waddr_o), '0);
        check_val("reset_wdata", bus.rf_wdata_o, '0);

        // Plain pipe write
        step(0, 1, 1, 5'd5, 64'hAA, 0, 5'd0, '0);
        idle();
        // Lone MDU result
        step(0, 0, 0, 5'd0, '0, 1, 5'd7, 64'h11);
        idle();
        idle();
        // WAW on x9: MDU write first, pipe write one cycle later
        step(0, 1, 1, 5'd4, 64'h44, 1, 5'd9, 64'h99);
        step(0, 1, 1, 5'd9, 64'h19, 0, 5'd0, '0);
        step(0, 1, 1, 5'd9, 64'h19, 0, 5'd0, '0);
        idle();
        // Starvation: x3 waits behind 4 pipe grants then is forced out
        step(0, 1, 1, 5'd1, 64'h100, 1, 5'd3, 64'h33);
        for (int i = 0; i < 6; i++) step(0, 1, 1, 5'd1 + 5'(i), 64'h200 + 64'(i), 0, 5'd0, '0);
        idle();
        // Fill FIFO while pipe busy: drain follows
        step(0, 1, 1, 5'd2, 64'h22, 1, 5'd10, 64'hA0);
        step(0, 1, 1, 5'd2, 64'h23, 1, 5'd11, 64'hB0);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 5'd2, 64'h24 + 64'(i), 1, 5'd12, 64'hC0 + 64'(i));
        idle();
        idle();
        // x0 targets consumed without write
        step(0, 1, 1, 5'd0, 64'hFF, 1, 5'd0, 64'hEE);
        idle();
        idle();
        // Reset with a full FIFO
        step(0, 1, 1, 5'd6, 64'h66, 1, 5'd13, 64'hD0);
        step(0, 1, 1, 5'd6, 64'h67, 1, 5'd14, 64'hE0);
        step(1, 0, 0, 5'd0, '0, 0, 5'd0, '0);
        idle();
        idle();

        // Random traffic over a small register range to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 299) == 0);
            pv  = ($urandom_range(0, 3) != 0);
            pw  = ($urandom_range(0, 3) != 0);
            prd = 5'($urandom_range(0, 3));
            pd  = {$urandom, $urandom};
            mv  = ($urandom_range(0, 2) == 0);
            mrd = 5'($urandom_range(0, 3));
            md  = {$urandom, $urandom};
            step(r, pv, pw, prd, pd, mv, mrd, md);
        end
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
